// File: rtl/debug_cmd_decoder.sv
// Host debug protocol decoder: turns received UART bytes into instruction memory
// writes and run/step/start/dump controls for the core and the dump serializer.
module debug_cmd_decoder #(
    parameter int unsigned INST_W          = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_INSTRUCTION = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_dump_busy,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [INST_W-1:0]     o_imem_data,
    output logic                  o_load_done,
    output logic                  o_mode_step,
    output logic                  o_step,
    output logic                  o_start,
    output logic                  o_dump_req,
    output logic [2:0]            o_dump_sel,
    output logic                  o_err
);

    localparam int unsigned BPW = INST_W / 8;
    localparam int unsigned BW  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_COUNT, LOAD_BYTE, DUMP_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [INST_W-1:0]     imem_data_q, imem_data_d;
    logic                  load_done_q, load_done_d;
    logic                  mode_step_q, mode_step_d;
    logic                  step_q, step_d;
    logic                  start_q, start_d;
    logic                  dump_req_q, dump_req_d;
    logic [2:0]            dump_sel_q, dump_sel_d;
    logic                  err_q, err_d;
    logic [BW-1:0]         byte_idx_q, byte_idx_d;
    logic [7:0]            word_idx_q, word_idx_d;
    logic [7:0]            nwords_q, nwords_d;
    logic [INST_W-1:0]     word_buf_q, word_buf_d;
    logic                  busy_seen_q, busy_seen_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            load_done_q <= 1'b0;
            mode_step_q <= 1'b0;
            step_q      <= 1'b0;
            start_q     <= 1'b0;
            dump_req_q  <= 1'b0;
            dump_sel_q  <= 3'd0;
            err_q       <= 1'b0;
            byte_idx_q  <= '0;
            word_idx_q  <= 8'd0;
            nwords_q    <= 8'd0;
            word_buf_q  <= '0;
            busy_seen_q <= 1'b0;
            wait_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            load_done_q <= load_done_d;
            mode_step_q <= mode_step_d;
            step_q      <= step_d;
            start_q     <= start_d;
            dump_req_q  <= dump_req_d;
            dump_sel_q  <= dump_sel_d;
            err_q       <= err_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            nwords_q    <= nwords_d;
            word_buf_q  <= word_buf_d;
            busy_seen_q <= busy_seen_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        load_done_d = load_done_q;
        mode_step_d = mode_step_q;
        step_d      = 1'b0;
        start_d     = 1'b0;
        dump_req_d  = 1'b0;
        dump_sel_d  = dump_sel_q;
        err_d       = err_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        nwords_d    = nwords_q;
        word_buf_d  = word_buf_q;
        busy_seen_d = busy_seen_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
                            dump_req_d  = 1'b1;
                            dump_sel_d  = i_rx_data[2:0];
                            busy_seen_d = 1'b0;
                            wait_cnt_d  = 2'd0;
                            state_d     = DUMP_WAIT;
                        end
                        8'h07: begin
                            load_done_d = 1'b0;
                            state_d     = LOAD_COUNT;
                        end
                        8'h08: mode_step_d = 1'b0;
                        8'h09: mode_step_d = 1'b1;
                        8'h0A: begin
                            if (mode_step_q) step_d = 1'b1;
                            else             err_d  = 1'b1;
                        end
                        8'h0D: begin
                            if (load_done_q) start_d = 1'b1;
                            else             err_d   = 1'b1;
                        end
                        8'h11:   err_d = 1'b0;
                        default: err_d = 1'b1;
                    endcase
                end
            end

            LOAD_COUNT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'd0) begin
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                    end else if (32'(i_rx_data) > MAX_INSTRUCTION) begin
                        err_d       = 1'b1;
                        load_done_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        nwords_d   = i_rx_data;
                        word_idx_d = 8'd0;
                        byte_idx_d = '0;
                        state_d    = LOAD_BYTE;
                    end
                end
            end

            LOAD_BYTE: begin
                // Every byte here is payload, including values that look like commands.
                if (i_rx_valid) begin
                    word_buf_d[8*byte_idx_q +: 8] = i_rx_data;
                    if (32'(byte_idx_q) == BPW - 1) begin
                        imem_we_d   = 1'b1;
                        imem_data_d = word_buf_d;
                        imem_addr_d = ADDR_WIDTH'({word_idx_q, 2'b00});
                        word_idx_d  = word_idx_q + 8'd1;
                        byte_idx_d  = '0;
                        if (word_idx_q == nwords_q - 8'd1) begin
                            load_done_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                    end
                end
            end

            DUMP_WAIT: begin
                if (i_rx_valid) err_d = 1'b1;
                // Leave on busy's falling edge, or after 4 cycles if busy never showed up.
                if (i_dump_busy)            busy_seen_d = 1'b1;
                else if (busy_seen_q)       state_d     = IDLE;
                else if (wait_cnt_q == 2'd3) state_d    = IDLE;
                else                        wait_cnt_d  = wait_cnt_q + 2'd1;
            end

            default: state_d = IDLE;
        endcase
    end

    assign o_imem_we   = imem_we_q;
    assign o_imem_addr = imem_addr_q;
    assign o_imem_data = imem_data_q;
    assign o_load_done = load_done_q;
    assign o_mode_step = mode_step_q;
    assign o_step      = step_q;
    assign o_start     = start_q;
    assign o_dump_req  = dump_req_q;
    assign o_dump_sel  = dump_sel_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Directed bench for debug_cmd_decoder: commands, program loads, step/start
// gating, dump handshake and reset during a load.
module tb_debug_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        dump_busy = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        load_done, mode_step, step, start, dump_req, err;
    logic [2:0]  dump_sel;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0, step_cnt = 0, start_cnt = 0, dump_cnt = 0;
    int snap;

    debug_cmd_decoder #(.INST_W(32), .ADDR_WIDTH(32), .MAX_INSTRUCTION(64)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_dump_busy(dump_busy), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
        .o_imem_data(imem_data), .o_load_done(load_done), .o_mode_step(mode_step),
        .o_step(step), .o_start(start), .o_dump_req(dump_req), .o_dump_sel(dump_sel),
        .o_err(err)
    );

    always #5 clk = ~clk;

    // Pulse counters: sample the value that was stable during the previous cycle.
    always @(posedge clk) begin
        if (imem_we)  we_cnt++;
        if (step)     step_cnt++;
        if (start)    start_cnt++;
        if (dump_req) dump_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Byte accepted at the posedge in between; its effect is visible on return.
    task automatic send(input logic [7:0] b);
        drive(b);
        idle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_we",    imem_we,   0);
        check("rst_addr",  imem_addr, 0);
        check("rst_data",  imem_data, 0);
        check("rst_done",  load_done, 0);
        check("rst_mode",  mode_step, 0);
        check("rst_pulse", {step, start, dump_req}, 0);
        check("rst_sel",   dump_sel,  0);
        check("rst_err",   err,       0);

        // start without a loaded program
        send(8'h0D);
        check("start_nold_pulse", start, 0);
        check("start_nold_err",   err,   1);
        send(8'h11);
        check("err_clear", err, 0);

        // two-word load; second word sent back-to-back
        send(8'h07);
        send(8'h02);
        send(8'h01); send(8'h01); send(8'h01);
        check("w0_early", imem_we, 0);
        send(8'h3C);
        check("w0_we",   imem_we,   1);
        check("w0_addr", imem_addr, 32'h0);
        check("w0_data", imem_data, 32'h3C010101);
        check("w0_done", load_done, 0);
        drive(8'h03); drive(8'h00); drive(8'h03); drive(8'h3C);
        idle();
        check("w1_we",   imem_we,   1);
        check("w1_addr", imem_addr, 32'h4);
        check("w1_data", imem_data, 32'h3C030003);
        check("w1_done", load_done, 1);
        idle(); idle();
        check("w_count", we_cnt, 2);
        check("w_we_low", imem_we, 0);

        send(8'h0D);
        check("start_ok", start, 1);
        check("start_ok_err", err, 0);

        // oversize count
        snap = we_cnt;
        send(8'h07);
        check("reload_clears_done", load_done, 0);
        send(8'h41);
        check("big_err",  err,       1);
        check("big_done", load_done, 0);
        idle(); idle();
        check("big_nowr", we_cnt, snap);
        send(8'h11);

        // MAX exactly is accepted as a count (no error)
        send(8'h07);
        send(8'h40);
        check("max_ok_err", err, 0);
        check("max_ok_done", load_done, 0);
        // abandon that load with a reset, tested more below
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;

        // zero-word load
        send(8'h07);
        send(8'h00);
        check("n0_done", load_done, 1);
        idle();
        check("n0_nowr", we_cnt, snap);

        // 0x0D as payload must not start the core
        snap = start_cnt;
        send(8'h07);
        send(8'h01);
        send(8'h0D); send(8'h00); send(8'h00); send(8'h00);
        check("pl_data", imem_data, 32'h0000000D);
        check("pl_addr", imem_addr, 32'h0);
        check("pl_done", load_done, 1);
        idle();
        check("pl_nostart", start_cnt, snap);

        // step gating
        send(8'h0A);
        check("step_cont", step, 0);
        check("step_cont_err", err, 1);
        send(8'h11);
        send(8'h09);
        check("mode_step", mode_step, 1);
        snap = step_cnt;
        send(8'h0A);
        check("step_pulse", step, 1);
        idle(); idle();
        check("step_once", step_cnt, snap + 1);

        // dump with busy handshake
        snap = dump_cnt;
        send(8'h03);
        check("dump_req", dump_req, 1);
        check("dump_sel3", dump_sel, 3);
        dump_busy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 10) begin rx_data = 8'h01; rx_valid = 1'b1; end
            else rx_valid = 1'b0;
        end
        check("dump_drop_err", err, 1);
        check("dump_drop_sel", dump_sel, 3);
        dump_busy = 1'b0;
        idle(); idle();
        check("dump_cnt1", dump_cnt, snap + 1);
        check("dump_mode_kept", mode_step, 1);
        send(8'h11);
        check("dump_idle_clear", err, 0);
        send(8'h05);
        check("dump_sel5", dump_sel, 5);
        // busy never rises: must time out back to IDLE without error
        repeat (6) idle();
        send(8'h08);
        check("timeout_idle", mode_step, 0);
        check("timeout_noerr", err, 0);
        check("dump_cnt2", dump_cnt, snap + 2);

        // reset part way through a 3-word load
        send(8'h07);
        send(8'h03);
        for (int i = 0; i < 6; i++) send(8'(8'h10 + i));
        idle();
        snap = we_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_done", load_done, 0);
        check("mid_rst_addr", imem_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(8'h20); send(8'h21);
        idle(); idle();
        check("mid_rst_nowr", we_cnt, snap);
        check("mid_rst_err", err, 1);
        send(8'h11);
        send(8'h07);
        send(8'h01);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        check("reload_we",   imem_we,   1);
        check("reload_addr", imem_addr, 32'h0);
        check("reload_data", imem_data, 32'hDDCCBBAA);
        check("reload_done", load_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
